// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-locked arbiter that merges N_SRC AXI-stream producers
// into one registered output stream. A winning source keeps the output until
// its TLAST beat transfers, or until MAX_BEATS beats force the packet closed.
module axis_packet_arbiter #(
   parameter int N_SRC     = 4,
   parameter int MAX_BEATS = 256,
   localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1,
   localparam int CW  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  real              s_tdata [N_SRC],
   input  logic [N_SRC-1:0] s_tvalid,
   input  logic [N_SRC-1:0] s_tlast,
   output logic [N_SRC-1:0] s_tready,
   output real              m_tdata,
   output logic             m_tvalid,
   output logic             m_tlast,
   input  logic             m_tready,
   output logic [IDW-1:0]   grant_id,
   output logic             busy,
   output logic             err_overlength
);

   typedef enum logic [0:0] {
      IDLE,
      LOCKED
   } state_t;

   state_t         r_state;
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] r_grant;
   logic [CW-1:0]  r_count;
   real            r_mdata;
   logic           r_mvalid;
   logic           r_mlast;
   logic           r_err;

   state_t         w_stateNext;
   logic [IDW-1:0] w_ptrNext;
   logic [IDW-1:0] w_grantNext;
   logic [CW-1:0]  w_countNext;
   real            w_dataNext;
   logic           w_validNext;
   logic           w_lastNext;
   logic           w_errNext;

   logic           w_anyValid;
   logic [IDW-1:0] w_winner;
   logic           w_slotFree;
   logic           w_accept;
   logic           w_force;
   logic           w_endPkt;
   logic [IDW-1:0] w_grantPlusOne;

   // Find the first valid source at or after the round-robin pointer; scanning
   // downward lets the lowest offset overwrite the others without a break.
   always_comb begin
      w_anyValid = 1'b0;
      w_winner   = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (s_tvalid[(int'(r_ptr) + k) % N_SRC]) begin
            w_anyValid = 1'b1;
            w_winner   = IDW'((int'(r_ptr) + k) % N_SRC);
         end
      end
   end

   assign w_slotFree     = !r_mvalid || m_tready;
   assign w_accept       = (r_state == LOCKED) && s_tvalid[r_grant] && w_slotFree;
   assign w_force        = (r_count == CW'(MAX_BEATS - 1)) && !s_tlast[r_grant];
   assign w_endPkt       = w_accept && (s_tlast[r_grant] || w_force);
   assign w_grantPlusOne = (r_grant == IDW'(N_SRC - 1)) ? '0 : r_grant + IDW'(1);

   // Only the locked source sees ready, and only when the output slot can take a beat.
   always_comb begin
      s_tready = '0;
      if (r_state == LOCKED) begin
         s_tready[r_grant] = w_slotFree;
      end
   end

   // Next-state logic: arbitration in IDLE, beat counting and packet close in LOCKED,
   // and the output slice loading a new beat or draining the held one.
   always_comb begin
      w_stateNext = r_state;
      w_ptrNext   = r_ptr;
      w_grantNext = r_grant;
      w_countNext = r_count;
      w_dataNext  = r_mdata;
      w_validNext = r_mvalid;
      w_lastNext  = r_mlast;
      w_errNext   = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_anyValid) begin
               w_grantNext = w_winner;
               w_stateNext = LOCKED;
            end
         end
         LOCKED: begin
            if (w_endPkt) begin
               w_countNext = '0;
               w_ptrNext   = w_grantPlusOne;
               w_stateNext = IDLE;
            end else if (w_accept) begin
               w_countNext = r_count + CW'(1);
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase

      if (w_accept) begin
         w_dataNext  = s_tdata[r_grant];
         w_validNext = 1'b1;
         w_lastNext  = s_tlast[r_grant] || w_force;
         w_errNext   = w_force;
      end else if (m_tready) begin
         w_validNext = 1'b0;
      end
   end

   // State and output-slice registers; reset drops any packet in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_grant  <= '0;
         r_count  <= '0;
         r_mdata  <= 0.0;
         r_mvalid <= 1'b0;
         r_mlast  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_ptr    <= w_ptrNext;
         r_grant  <= w_grantNext;
         r_count  <= w_countNext;
         r_mdata  <= w_dataNext;
         r_mvalid <= w_validNext;
         r_mlast  <= w_lastNext;
         r_err    <= w_errNext;
      end
   end

   assign m_tdata        = r_mdata;
   assign m_tvalid       = r_mvalid;
   assign m_tlast        = r_mlast;
   assign grant_id       = r_grant;
   assign busy           = (r_state == LOCKED);
   assign err_overlength = r_err;

endmodule
